// File: rtl/regfile.sv
// Register file: 2**ADDR_W registers of DATA_W bits, one write port, two
// combinational read ports with write-to-read forwarding. Register 0 is
// hardwired to zero.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - asynchronous active-low reset, clears every register
//   regwrite  - write enable
//   wreg      - write address
//   wdata     - write data
//   rreg1/2   - read addresses
//   rdata1/2  - read data (zero-latency, forwarded from a pending write)
module regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wreg,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rreg1,
    input  logic [ADDR_W-1:0] rreg2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;

    // A write is only live out of reset and never to register 0; the same
    // qualifier gates forwarding so a discarded write is never visible.
    assign wr_en = reset && regwrite && (wreg != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wreg] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (reset && (rreg1 != '0)) begin
            if (wr_en && (rreg1 == wreg)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[rreg1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (reset && (rreg2 != '0)) begin
            if (wr_en && (rreg2 == wreg)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[rreg2];
            end
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios followed by random
// traffic, with expected read data queued by the stimulus and compared by an
// independent monitor on the falling clock edge.
module tb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              regwrite = 1'b0;
    logic [ADDR_W-1:0] wreg = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [ADDR_W-1:0] rreg1 = '0;
    logic [ADDR_W-1:0] rreg2 = '0;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        int                a1;
        int                a2;
        string             tag;
    } exp_t;

    exp_t              sbq [$];
    logic [DATA_W-1:0] model [NREGS];
    int                checks = 0;
    int                errors = 0;

    regfile #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .regwrite(regwrite),
        .wreg    (wreg),
        .wdata   (wdata),
        .rreg1   (rreg1),
        .rreg2   (rreg2),
        .rdata1  (rdata1),
        .rdata2  (rdata2)
    );

    always #5 clk = ~clk;

    // Architectural view of a read: zero in reset or for r0, the pending
    // write value if this address is being written, else the stored value.
    function automatic logic [DATA_W-1:0] ref_read(input int a);
        if (!reset || a == 0) return '0;
        if (regwrite && int'(wreg) == a) return wdata;
        return model[a];
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end
    endtask

    // Apply inputs for one cycle (called 1 time unit after a rising edge),
    // queue the expected reads, then commit the write at the next edge.
    task automatic drive(input logic rw, input int wr, input logic [DATA_W-1:0] wd,
                         input int r1, input int r2, input string tag);
        exp_t e;
        regwrite = rw;
        wreg     = ADDR_W'(wr);
        wdata    = wd;
        rreg1    = ADDR_W'(r1);
        rreg2    = ADDR_W'(r2);
        e.d1  = ref_read(r1);
        e.d2  = ref_read(r2);
        e.a1  = r1;
        e.a2  = r2;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        if (reset && rw && wr != 0) model[wr] = wd;
        #1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (rdata1 !== e.d1) begin
                errors++;
                $display("FAIL %s rdata1 rreg1=%0d got=%h exp=%h", e.tag, e.a1, rdata1, e.d1);
            end
            checks++;
            if (rdata2 !== e.d2) begin
                errors++;
                $display("FAIL %s rdata2 rreg2=%0d got=%h exp=%h", e.tag, e.a2, rdata2, e.d2);
            end
        end
    end

    initial begin
        set_reset(1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 4, 32'h5555_5555, 4, 0, "in_reset");
        set_reset(1'b1);

        // Reset then read
        drive(1'b0, 0, '0, 1, 31, "reset_read");

        // Write then read on both ports
        drive(1'b1, 1, 32'd14, 0, 0, "wr_r1");
        drive(1'b0, 0, '0, 1, 1, "read_r1");

        // Register zero discards writes, including no forwarding
        drive(1'b1, 0, 32'hDEAD_BEEF, 0, 0, "zero_wr");
        drive(1'b0, 0, '0, 0, 0, "zero_rd");

        // Forwarding
        drive(1'b1, 5, 32'd7, 0, 0, "wr_r5");
        drive(1'b1, 5, 32'd9, 5, 5, "fwd_r5");
        drive(1'b0, 0, '0, 5, 1, "after_fwd");

        // Async reset mid-cycle, write ignored while in reset
        drive(1'b1, 3, 32'h1234_5678, 3, 0, "wr_r3");
        drive(1'b0, 0, '0, 3, 3, "rd_r3");
        set_reset(1'b0);
        drive(1'b1, 3, 32'hAAAA_AAAA, 3, 3, "async_rst");
        set_reset(1'b1);
        drive(1'b0, 0, '0, 3, 1, "post_rst");

        // Dual-port sweep
        for (int i = 1; i < NREGS; i++) drive(1'b1, i, DATA_W'(i * 3), 0, 0, "sweep_wr");
        for (int i = 0; i < NREGS; i++) drive(1'b0, 0, '0, i, 31 - i, "sweep_rd");

        // Random traffic with occasional mid-run resets
        for (int n = 0; n < 600; n++) begin
            int w;
            int r1;
            int r2;
            w  = int'($urandom_range(0, NREGS - 1));
            r1 = ($urandom_range(0, 3) == 0) ? w : int'($urandom_range(0, NREGS - 1));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : int'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 59) == 0) set_reset(1'b0);
            else if (!reset) set_reset(1'b1);
            drive(1'($urandom_range(0, 1)), w, $urandom, r1, r2, "random");
        end
        set_reset(1'b1);

        // Let the monitor drain the last queued expectation
        for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
